// File: rtl/mux_arb_pkg.sv
// Shared constants for the N-channel registered arbitrating mux.
// Mode encoding 2'b11 is treated as fixed priority by the top.
package mux_arb_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_FIXED  = 2'b01;
   localparam logic [1:0] MODE_RR     = 2'b10;

endpackage : mux_arb_pkg

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester found searching from ptr upward, wrapping.
// With ptr tied to zero it degenerates into a lowest-index-first fixed priority arbiter.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  idx
);

   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found && req[(int'(ptr) + k) % NUM_CH]) begin
            found = 1'b1;
            idx   = SEL_W'((int'(ptr) + k) % NUM_CH);
            grant[(int'(ptr) + k) % NUM_CH] = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/mux_arb_n.sv
// N-channel WIDTH-bit registered mux with valid/ready handshake and run-time selectable
// arbitration (direct select, fixed priority, round-robin); one output register stage.
module mux_arb_n
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 16,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_CH*WIDTH-1:0]   in_data,
   input  logic [NUM_CH-1:0]         in_valid,
   output logic [NUM_CH-1:0]         in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_ch,
   output logic [CNT_W-1:0]          xfer_cnt
);

   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic [CNT_W-1:0]  xfer_cnt_q,  xfer_cnt_d;
   logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

   logic [WIDTH-1:0]  lane [NUM_CH];
   logic [NUM_CH-1:0] fix_grant, rr_grant, dir_grant, gnt_vec;
   logic [SEL_W-1:0]  fix_idx, rr_idx, gnt_idx;
   logic              load_en, xfer;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign lane[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(.NUM_CH(NUM_CH)) u_fixed_arb (
      .req   (in_valid),
      .ptr   ('0),
      .grant (fix_grant),
      .idx   (fix_idx)
   );

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arb (
      .req   (in_valid),
      .ptr   (rr_ptr_q),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // An out-of-range sel matches no channel, so it grants nothing.
   always_comb begin
      dir_grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dir_grant[i] = in_valid[i] && (sel == SEL_W'(i));
      end
   end

   always_comb begin
      gnt_vec = fix_grant;
      gnt_idx = fix_idx;
      case (mode)
         MODE_DIRECT: begin
            gnt_vec = dir_grant;
            gnt_idx = sel;
         end
         MODE_RR: begin
            gnt_vec = rr_grant;
            gnt_idx = rr_idx;
         end
         default: ;
      endcase
   end

   // Ready is withheld while in reset: a word accepted then would be silently dropped.
   assign load_en  = rst_n && (!out_valid_q || out_ready);
   assign xfer     = load_en && (|gnt_vec);
   assign in_ready = load_en ? gnt_vec : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      xfer_cnt_d  = xfer_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = lane[gnt_idx];
         out_valid_d = 1'b1;
         out_ch_d    = gnt_idx;
         if (xfer_cnt_q != '1) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
         end
         if (mode == MODE_RR) begin
            rr_ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
         end
      end else if (load_en) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         xfer_cnt_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         xfer_cnt_q  <= xfer_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule : mux_arb_n

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (4 channels, 8-bit data, 4-bit counter to exercise saturation).
// Inputs change 1 time unit after the rising edge; outputs are checked at that point too.
module tb_mux_arb_n;

   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;
   localparam int SEL_W  = 2;

   logic                    clk;
   logic                    rst_n;
   logic [1:0]              mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_ch;
   logic [CNT_W-1:0]        xfer_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [WIDTH-1:0] lane_val [NUM_CH];

   mux_arb_n #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .xfer_cnt  (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("  ok   %-22s = %0h", tag, got);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      lane_val[0] = 8'h10;
      lane_val[1] = 8'h21;
      lane_val[2] = 8'hA5;
      lane_val[3] = 8'h43;
      in_data = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};

      // 1: reset with every channel requesting
      rst_n     = 1'b0;
      mode      = 2'b10;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready",  32'(in_ready),  32'd0);
      chk("rst xfer_cnt",  32'(xfer_cnt),  32'd0);
      chk("rst out_data",  32'(out_data),  32'd0);
      chk("rst out_ch",    32'(out_ch),    32'd0);

      // 2: direct select
      rst_n    = 1'b1;
      mode     = 2'b00;
      sel      = 2'd2;
      in_valid = 4'b0100;
      #1;
      chk("dir in_ready sel2", 32'(in_ready), 32'b0100);
      tick();
      chk("dir out_data",  32'(out_data),  32'hA5);
      chk("dir out_ch",    32'(out_ch),    32'd2);
      chk("dir out_valid", 32'(out_valid), 32'd1);
      chk("dir xfer_cnt",  32'(xfer_cnt),  32'd1);
      sel = 2'd3;
      #1;
      chk("dir in_ready sel3", 32'(in_ready), 32'd0);
      tick();
      chk("dir idle out_valid", 32'(out_valid), 32'd0);
      chk("dir idle data hold", 32'(out_data),  32'hA5);
      chk("dir idle ch hold",   32'(out_ch),    32'd2);

      // 3: fixed priority, ch1 always beats ch3
      mode     = 2'b01;
      in_valid = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("fix in_ready c%0d", c), 32'(in_ready), 32'b0010);
         tick();
         chk($sformatf("fix out_ch c%0d", c),   32'(out_ch),   32'd1);
         chk($sformatf("fix out_data c%0d", c), 32'(out_data), 32'h21);
      end
      chk("fix xfer_cnt", 32'(xfer_cnt), 32'd4);

      // 4: round-robin from a fresh pointer
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      mode     = 2'b10;
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("rr out_ch k%0d", k),   32'(out_ch),   32'(k % 4));
         chk($sformatf("rr out_data k%0d", k), 32'(out_data), 32'(lane_val[k % 4]));
      end
      chk("rr xfer_cnt 8", 32'(xfer_cnt), 32'd8);

      // 5: back-pressure holds ch0's word; ch1 is next after release
      tick();
      chk("bp load ch0", 32'(out_ch), 32'd0);
      out_ready = 1'b0;
      #1;
      chk("bp in_ready stall", 32'(in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("bp data hold c%0d", c),  32'(out_data),  32'h10);
         chk($sformatf("bp valid hold c%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp ready c%0d", c),      32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 32'b0010);
      tick();
      chk("bp resume ch1",   32'(out_ch),   32'd1);
      chk("bp resume data1", 32'(out_data), 32'h21);
      tick();
      chk("bp resume ch2", 32'(out_ch),   32'd2);
      chk("bp xfer_cnt",   32'(xfer_cnt), 32'd11);

      // 6: counter saturation, then reset while the output is stalled
      for (int k = 0; k < 20; k++) tick();
      chk("sat xfer_cnt", 32'(xfer_cnt), 32'hF);
      out_ready = 1'b0;
      tick();
      chk("pre-rst out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("in-rst in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("mid-rst out_valid", 32'(out_valid), 32'd0);
      chk("mid-rst xfer_cnt",  32'(xfer_cnt),  32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid-rst rr_ptr0", 32'(in_ready), 32'b0001);

      // mode 11 behaves as fixed priority
      mode     = 2'b11;
      in_valid = 4'b1100;
      #1;
      chk("mode11 in_ready", 32'(in_ready), 32'b0100);
      tick();
      chk("mode11 out_ch", 32'(out_ch), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mux_arb_n
